dsp48a1_mac_sequencer: RTL

//  Initiator-side controller for one Spartan6_DSP48A1 slice: accepts a valid/ready stream of signed
//  18x18 sample pairs and drives A/B/OPMODE/CE/RST so the slice computes a multiply-accumulate.
//  P is captured when the last beat drains, then presented on a valid/ready result port.

---
 rtl/dsp48a1_pkg.sv | 20 ++
 rtl/dsp_lat_pipe.sv | 24 ++
 rtl/dsp48a1_mac_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp48a1_pkg;
  localparam int W1_DEF = 18;
  localparam int W2_DEF = 48;
  localparam int CNT_W  = 11;

  // OPMODE = {post-sub, pre-sub, carry, pre-mode, Z[1:0], X[1:0]}
  localparam logic [7:0] OP_NONE      = 8'h00;
  localparam logic [7:0] OP_FIRST     = 8'h01;
  localparam logic [7:0] OP_ACC       = 8'h09;
  localparam logic [7:0] OP_HOLD      = 8'h08;
  localparam logic [7:0] OP_FIRST_RND = 8'h0D;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} seq_state_t;

  typedef struct packed {
    logic vld;
    logic last;
  } beat_tag_t;
endpackage

// File: rtl/dsp_lat_pipe.sv
// Fixed-depth delay line of beat tags, lined up with the slice's A1/B1 -> M -> P path.
module dsp_lat_pipe
  import dsp48a1_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic      CLK,
  input  logic      RST,
  input  beat_tag_t din,
  output beat_tag_t dout
);
  beat_tag_t [STAGES:1] vld_pipe;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[STAGES];
endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice through a streamed multiply-accumulate and returns P.
// Build option: DSP_SEQ_ROUND_EN adds a rounding constant through the C port once per result.
module dsp48a1_mac_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH1    = W1_DEF,
  parameter int WIDTH2    = W2_DEF,
  parameter int LAT       = 3,
  parameter int MAX_TAPS  = 1024,
  parameter int RND_SHIFT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [WIDTH1-1:0] S_A,
  input  logic [WIDTH1-1:0] S_B,
  input  logic              S_LAST,
  output logic [WIDTH1-1:0] A,
  output logic [WIDTH1-1:0] B,
  output logic [WIDTH1-1:0] D,
  output logic [WIDTH2-1:0] C,
  output logic [7:0]        OPMODE,
  output logic              CARRYIN,
  output logic              CEA,
  output logic              CEB,
  output logic              CEC,
  output logic              CED,
  output logic              CEM,
  output logic              CEOPMODE,
  output logic              CECARRYIN,
  output logic              CEP,
  output logic              RSTA,
  output logic              RSTB,
  output logic              RSTC,
  output logic              RSTD,
  output logic              RSTM,
  output logic              RSTOPMODE,
  output logic              RSTCARRYIN,
  output logic              RSTP,
  input  logic [WIDTH2-1:0] P,
  output logic              R_VALID,
  input  logic              R_READY,
  output logic [WIDTH2-1:0] R_DATA,
  output logic [CNT_W-1:0]  R_COUNT
);
`ifdef DSP_SEQ_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif
  localparam logic [WIDTH2-1:0] RND_C    = WIDTH2'(1) << (RND_SHIFT - 1);
  localparam logic [7:0]        OP_START = RND_EN ? OP_FIRST_RND : OP_FIRST;

  seq_state_t       state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fire, is_last, cap;
  beat_tag_t        tag_in, tag_out;

  assign fire     = S_VALID & S_READY;
  assign cnt_next = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  assign is_last  = S_LAST | (cnt_next == CNT_W'(MAX_TAPS));

  // A/B go straight to the slice's A1/B1 regs so the beat enters the pipe the cycle it is accepted
  assign A       = fire ? S_A : '0;
  assign B       = fire ? S_B : '0;
  assign D       = '0;
  assign C       = RND_EN ? RND_C : '0;
  assign CARRYIN = 1'b0;

  assign CEA       = ~RST;
  assign CEB       = ~RST;
  assign CEM       = ~RST;
  assign CEOPMODE  = ~RST;
  assign CEP       = ~RST;
  assign CEC       = 1'b1;
  assign CED       = 1'b1;
  assign CECARRYIN = 1'b1;

  assign RSTA       = RST;
  assign RSTB       = RST;
  assign RSTC       = RST;
  assign RSTD       = RST;
  assign RSTM       = RST;
  assign RSTOPMODE  = RST;
  assign RSTCARRYIN = RST;
  assign RSTP       = RST;

  assign tag_in = '{vld: fire, last: fire & is_last};

  dsp_lat_pipe #(.STAGES(LAT)) u_lat (
    .CLK  (CLK),
    .RST  (RST),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign cap = tag_out.vld & tag_out.last;

  // OPMODE is registered here and again by OPMODEREG, landing alongside M
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      S_READY <= 1'b0;
      R_VALID <= 1'b0;
      R_DATA  <= '0;
      R_COUNT <= '0;
      OPMODE  <= OP_NONE;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          S_READY <= 1'b1;
          OPMODE  <= OP_NONE;
          if (fire) begin
            cnt    <= cnt_next;
            OPMODE <= OP_START;
            if (is_last) begin
              state   <= DRAIN;
              S_READY <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          OPMODE <= fire ? OP_ACC : OP_HOLD;
          if (fire) begin
            cnt <= cnt_next;
            if (is_last) begin
              state   <= DRAIN;
              S_READY <= 1'b0;
            end
          end
        end
        DRAIN: begin
          OPMODE <= OP_HOLD;
          if (cap) begin
            R_DATA  <= P;
            R_COUNT <= cnt;
            R_VALID <= 1'b1;
            state   <= RESULT;
          end
        end
        RESULT: begin
          OPMODE <= OP_HOLD;
          if (R_READY) begin
            R_VALID <= 1'b0;
            S_READY <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          S_READY <= 1'b0;
        end
      endcase
    end
  end
endmodule
